// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Optional feature: define REGFILE_BYPASS_EN to enable write-through forwarding.
package regfile_pkg;

    // Default geometry of the register file
    localparam int XLEN_DEFAULT  = 64;
    localparam int NREGS_DEFAULT = 32;

    // Write-port indices; a higher index has priority on a same-address collision
    localparam int NWP     = 2;
    localparam int WP_ALU  = 0;
    localparam int WP_LOAD = 1;

    // Address width needed to select one of nRegs registers
    function automatic int addrWidth(input int nRegs);
        return (nRegs > 1) ? $clog2(nRegs) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with a registered population count.
// A writeback clears a register's busy bit, an issue sets it, and when both
// target the same register in one cycle the set wins. x0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = addrWidth(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busyNext;

    // Count of set bits in the busy vector
    function automatic logic [AW:0] popCount(input logic [NREGS-1:0] vec);
        logic [AW:0] cnt;
        cnt = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt = cnt + {{AW{1'b0}}, vec[r]};
        end
        return cnt;
    endfunction

    // Next busy vector: clears from both writeback ports first, then the issue set
    always_comb begin
        // NOTE: start from the current value so every path assigns busyNext; no latch is inferred.
        busyNext = busy;
        if (we0 && (waddr0 != '0)) begin
            busyNext[waddr0] = 1'b0;
        end
        if (we1 && (waddr1 != '0)) begin
            busyNext[waddr1] = 1'b0;
        end
        // Applied last so a same-cycle issue overrides a writeback clear
        if (issue_valid && (issue_rd != '0)) begin
            busyNext[issue_rd] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Busy vector and its count; the count trails the vector by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // NOTE: non-blocking here so busy_cnt samples busy from before this edge.
            busy     <= busyNext;
            busy_cnt <= popCount(busy);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational read ports, two write
// ports (ALU and load writeback, load wins on collision) and a busy scoreboard.
// x0 reads as zero and ignores writes and issues.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and clear the reported busy bit) onto matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = 2,
    parameter int AW    = addrWidth(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  we1,
    input  logic [AW-1:0]         waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Write ports gathered into arrays indexed by write-port number
    logic            wrEn   [NWP];
    logic [AW-1:0]   wrAddr [NWP];
    logic [XLEN-1:0] wrData [NWP];

    assign wrEn[WP_ALU]    = we0;
    assign wrAddr[WP_ALU]  = waddr0;
    assign wrData[WP_ALU]  = wdata0;
    assign wrEn[WP_LOAD]   = we1;
    assign wrAddr[WP_LOAD] = waddr1;
    assign wrData[WP_LOAD] = wdata1;

    // Register storage; ports applied in ascending order so the load port wins a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset on purpose; every register must read 0 right after reset.
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (wrEn[p] && (wrAddr[p] != '0)) begin
                    regs[wrAddr[p]] <= wrData[p];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) uScoreboard (
        .clk         (clk),
        .rst         (rst),
        .we0         (we0),
        .waddr0      (waddr0),
        .we1         (we1),
        .waddr1      (waddr1),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .busy_cnt    (busy_cnt)
    );

    for (genvar i = 0; i < NREAD; i++) begin : gRead
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[i*AW +: AW];

        // Read mux for this port, with optional forwarding of a same-cycle write
        always_comb begin
            data = (addr == '0) ? '0 : regs[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is suppressed during reset so in-flight writes stay invisible
            if (!rst && (addr != '0)) begin
                for (int p = 0; p < NWP; p++) begin
                    if (wrEn[p] && (wrAddr[p] == addr)) begin
                        data = wrData[p];
                        bsy  = issue_valid && (issue_rd == addr);
                    end
                end
            end
`endif
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = bsy;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-issue RISC-V integer register file.
- Configurable XLEN, register count and number of read ports; two write ports (ALU writeback, load writeback).
- Per-register scoreboard (busy bits) so the issue stage can detect pending writes.
- Sits between decode/issue and the writeback stage of the datapath.

Parameters:
- XLEN, 64, register width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NREAD, 2, number of independent read ports (1..4).
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rd_addr  in  NREAD*AW  packed read addresses; port i occupies [i*AW +: AW].
- rd_data  out  NREAD*XLEN  packed read data; port i occupies [i*XLEN +: XLEN].
- rd_busy  out  NREAD  busy bit of the register addressed by each read port.
- we0  in  1  write enable, port 0 (ALU).
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (load).
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  AW  destination register of the issuing instruction.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Reset (async, rst=1):
  - all registers clear to 0; all busy bits clear; busy_cnt=0.
  - Takes effect immediately, even mid-cycle; in-flight writes/issues are discarded.
  - After reset, rd_data reads 0 and rd_busy reads 0 for every port.
- Register x0: reads always 0; writes to address 0 are ignored; x0 is never busy (issue_rd=0 is ignored).
- Reads: combinational, zero latency; rd_data[i] = regs[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]].
- Writes: at posedge clk when weN=1 and waddrN!=0, regs[waddrN] <= wdataN.
  - Both ports writing the same address in the same cycle: port 1 wins; wdata0 is dropped.
- Scoreboard, evaluated at each posedge:
  - A write on either port with addr!=0 clears busy[addr].
  - issue_valid with issue_rd!=0 sets busy[issue_rd].
  - Issue and writeback to the same register in the same cycle: set wins (the new producer is pending).
  - Issue to an already-busy register: it stays busy (WAW is tolerated; no count).
- busy_cnt: population count of the busy vector, registered and updated one cycle after the busy change.
  - Range 0..NREGS-1 (x0 is excluded).
- Out-of-range addresses are impossible (NREGS is a power of two).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. For each read port, if weN=1 and waddrN==rd_addr[i]!=0 in the current cycle:
  - rd_data[i] returns the incoming wdataN (port 1 has priority over port 0);
  - rd_busy[i] reads 0 unless issue_valid targets the same register that cycle.
- Not defined: reads return the stored value; a same-cycle write becomes visible only after the clock edge, and rd_busy stays 1 until then.

Decomposition:
- Package regfile_pkg:
  - default XLEN/NREGS constants;
  - address-width function;
  - write-port index constants WP_ALU=0, WP_LOAD=1.
- Sub-module regfile_scoreboard: owns the busy vector, set/clear priority and the busy_cnt popcount register.
- The top level holds the storage array, read muxes and optional bypass.

Test Plan:
- Reset then read all ports at addresses 0..31: every rd_data=0, every rd_busy=0, busy_cnt=0.
- we0=1, waddr0=5, wdata0=0xDEAD_BEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF; write 0x1234 to x0 -> x0 reads 0.
- Same cycle we0 (addr 7, data 0xAAAA) and we1 (addr 7, data 0x5555) -> x7=0x5555.
- issue_valid, issue_rd=9 -> rd_busy=1 for x9, busy_cnt=1 one cycle later. Then we1 addr 9 together with issue_rd=9 -> x9 stays busy. Then we1 addr 9 alone -> busy clears, busy_cnt=0.
- Bypass: rd_addr1=3, we0 addr 3 data 0x77 in the same cycle -> rd_data1=0x77 with REGFILE_BYPASS_EN defined, old value without it.
- Assert rst mid-sequence with 4 busy registers and nonzero contents -> all outputs read 0 immediately, before the next clk edge.
